// File: rtl/cdma_despreader.sv
// ---------------------------------------------------------------------------
// cdma_despreader
//   Receive-side correlator for one crossbar output port. Each accepted chip
//   of the summed channel value is added to (code bit 0) or subtracted from
//   (code bit 1) a signed accumulator. After CODE_WIDTH chips the sum is
//   divided by CODE_WIDTH with an arithmetic shift, which recovers this
//   port's signed data word. The word is held in a valid/ready output
//   register.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   sum_valid    sum carries a valid chip this cycle
//   frame_start  qualified by sum_valid; marks chip 0 of a frame
//   sum          signed channel sum, DATA_WIDTH+LOG_CODE_WIDTH bits
//   code         spreading code, captured on an accepted frame_start
//   data_out     recovered signed data word
//   out_valid    data_out valid; held until out_ready
//   out_ready    downstream accepts data_out
//   overrun      1-cycle pulse: a completed result was dropped
//   frame_err    1-cycle pulse: frame_start arrived mid-frame
//
// Configuration macro
//   CDMA_DESPREAD_SAT_EN  defined: the shifted result saturates to the signed
//                         DATA_WIDTH range; undefined: low DATA_WIDTH bits.
// ---------------------------------------------------------------------------
module cdma_despreader #(
    parameter int DATA_WIDTH     = 8,
    parameter int CODE_WIDTH     = 8,
    parameter int LOG_CODE_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sum_valid,
    input  logic                                 frame_start,
    input  logic [DATA_WIDTH+LOG_CODE_WIDTH-1:0] sum,
    input  logic [CODE_WIDTH-1:0]                code,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overrun,
    output logic                                 frame_err
);

    localparam int SUM_W = DATA_WIDTH + LOG_CODE_WIDTH;
    // CODE_WIDTH chips of a SUM_W-bit value plus one sign bit of headroom:
    // the accumulator can never overflow.
    localparam int ACC_W = DATA_WIDTH + 2 * LOG_CODE_WIDTH + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [LOG_CODE_WIDTH-1:0] LAST_CHIP = LOG_CODE_WIDTH'(CODE_WIDTH - 1);

    logic [0:0]                state;
    logic [LOG_CODE_WIDTH-1:0] chip_idx;
    logic [CODE_WIDTH-1:0]     code_q;
    logic signed [ACC_W-1:0]   acc;

    logic                      restart;
    logic                      chip_neg;
    logic                      final_chip;
    logic                      complete;
    logic signed [ACC_W-1:0]   sum_ext;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [DATA_WIDTH-1:0]     result;

`ifdef CDMA_DESPREAD_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    assign sum_ext = {{(ACC_W - SUM_W){sum[SUM_W-1]}}, sum};

    // Any accepted frame_start (from IDLE or mid-frame) begins a new frame
    // whose chip 0 is weighted by the live code input, not code_q.
    assign restart    = sum_valid && frame_start;
    assign final_chip = (state == ACCUM) && (chip_idx == LAST_CHIP);
    assign complete   = sum_valid && !frame_start && final_chip;

    // NOTE: every always_comb output gets a value on every path (defaults
    // first), so no latch can be inferred.
    always_comb begin
        chip_neg = code_q[chip_idx];
        if (state == IDLE || frame_start) begin
            chip_neg = code[0];
        end
        term    = chip_neg ? -sum_ext : sum_ext;
        acc_sum = acc + term;
        shifted = acc_sum >>> LOG_CODE_WIDTH;
`ifdef CDMA_DESPREAD_SAT_EN
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result = DATA_WIDTH'(shifted);
        end
`else
        result = DATA_WIDTH'(shifted);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chip_idx  <= '0;
            acc       <= '0;
            code_q    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            // Output register: a completing frame wins over the handshake
            // clear; if the held word is not being taken, drop the new one.
            if (complete) begin
                if (!out_valid || out_ready) begin
                    data_out  <= result;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (restart) begin
                // A mid-frame start (including on the final chip) abandons
                // the partial sum.
                if (state == ACCUM) begin
                    frame_err <= 1'b1;
                end
                state    <= ACCUM;
                code_q   <= code;
                acc      <= term;
                chip_idx <= LOG_CODE_WIDTH'(1);
            end else if (sum_valid && state == ACCUM) begin
                if (final_chip) begin
                    state    <= IDLE;
                    chip_idx <= '0;
                    acc      <= '0;
                end else begin
                    acc      <= acc_sum;
                    chip_idx <= chip_idx + LOG_CODE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cdma_despreader.sv
// ---------------------------------------------------------------------------
// tb_cdma_despreader
//   Self-checking bench for cdma_despreader (DATA_WIDTH=8, CODE_WIDTH=8).
//   A frame-level reference model collects the chips of the current frame
//   in a queue and, when the frame is full, correlates them with the code
//   using integer arithmetic. Directed scenarios are followed by a
//   randomized run; all outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_cdma_despreader;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int LW = 3;

    logic              clk;
    logic              rst;
    logic              sum_valid;
    logic              frame_start;
    logic [DW+LW-1:0]  sum;
    logic [CW-1:0]     code;
    logic [DW-1:0]     data_out;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              frame_err;

    cdma_despreader #(
        .DATA_WIDTH    (DW),
        .CODE_WIDTH    (CW),
        .LOG_CODE_WIDTH(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sum_valid  (sum_valid),
        .frame_start(frame_start),
        .sum        (sum),
        .code       (code),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_chips[$];
    logic [CW-1:0] m_code;
    logic [DW-1:0] m_data;
    logic        m_valid;
    logic        m_ovr;
    logic        m_ferr;

    // Bench drive state
    logic        rdy;
    logic        rst_r;
    int          fv[CW];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int correlate(input logic [CW-1:0] c);
        int a;
        a = 0;
        for (int j = 0; j < CW; j++) begin
            a += c[j] ? -m_chips[j] : m_chips[j];
        end
        return a;
    endfunction

    function automatic logic [DW-1:0] to_word(input int acc_val);
        int r;
        r = acc_val >>> LW;
`ifdef CDMA_DESPREAD_SAT_EN
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`endif
        return r[DW-1:0];
    endfunction

    // Called once per rising edge with the inputs that edge samples.
    task automatic model_step();
        logic done;
        logic [DW-1:0] res;
        done   = 1'b0;
        res    = '0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (rst) begin
            m_chips.delete();
            m_code  = '0;
            m_data  = '0;
            m_valid = 1'b0;
            return;
        end
        if (sum_valid) begin
            if (frame_start) begin
                if (m_chips.size() > 0) m_ferr = 1'b1;
                m_chips.delete();
                m_code = code;
                m_chips.push_back(int'($signed(sum)));
            end else if (m_chips.size() > 0) begin
                m_chips.push_back(int'($signed(sum)));
                if (m_chips.size() == CW) begin
                    res  = to_word(correlate(m_code));
                    done = 1'b1;
                    m_chips.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_data  = res;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic sv, input logic fs, input int s, input logic [CW-1:0] c);
        sum_valid   = sv;
        frame_start = fs;
        sum         = s[DW+LW-1:0];
        code        = c;
        out_ready   = rdy;
        rst         = rst_r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out_valid", int'(out_valid), int'(m_valid));
        check("data_out", int'($signed(data_out)), int'($signed(m_data)));
        check("overrun", int'(overrun), int'(m_ovr));
        check("frame_err", int'(frame_err), int'(m_ferr));
    endtask

    // Sends fv[0..CW-1] as one frame; optional stall inserted before chip stall_at.
    task automatic send_frame(input logic [CW-1:0] c, input int stall_at, input int stall_len);
        for (int j = 0; j < CW; j++) begin
            if (j == stall_at) begin
                for (int k = 0; k < stall_len; k++) cycle(1'b0, 1'b0, 0, c);
            end
            cycle(1'b1, j == 0, fv[j], c);
        end
    endtask

    task automatic fill(input int v);
        for (int j = 0; j < CW; j++) fv[j] = v;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, '0);
    endtask

    initial begin
        rdy   = 1'b1;
        rst_r = 1'b1;
        m_chips.delete();
        m_code  = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        idle(3);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_data_out", int'(data_out), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_frame_err", int'(frame_err), 0);
        rst_r = 1'b0;
        idle(2);

        // 1: code 00, all +5
        fill(5);
        send_frame(8'h00, -1, 0);
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_data", int'($signed(data_out)), 5);
        idle(2);

        // 2: code AA, alternating -3,+3
        for (int j = 0; j < CW; j++) fv[j] = (j % 2 == 0) ? -3 : 3;
        send_frame(8'hAA, -1, 0);
        check("t2_data", int'(data_out), 8'hFD);
        idle(2);

        // 3: two users on one channel, decoded with each code
        for (int j = 0; j < CW; j++) fv[j] = (j % 2 == 0) ? 2 : 6;
        send_frame(8'hAA, -1, 0);
        check("t3_user_b", int'($signed(data_out)), -2);
        idle(1);
        send_frame(8'h00, -1, 0);
        check("t3_user_a", int'($signed(data_out)), 4);
        idle(2);

        // 4: stall three cycles mid-frame
        fill(5);
        send_frame(8'h00, 4, 3);
        check("t4_latency_valid", int'(out_valid), 1);
        check("t4_data", int'($signed(data_out)), 5);
        idle(2);

        // 5: restart at chip 4
        for (int j = 0; j < 4; j++) cycle(1'b1, j == 0, 5, 8'h00);
        cycle(1'b1, 1'b1, 7, 8'h00);
        check("t5_frame_err", int'(frame_err), 1);
        check("t5_no_output", int'(out_valid), 0);
        for (int j = 1; j < CW; j++) cycle(1'b1, 1'b0, 7, 8'h00);
        check("t5_data", int'($signed(data_out)), 7);
        idle(2);

        // 6: overrun with out_ready low
        rdy = 1'b0;
        fill(5);
        send_frame(8'h00, -1, 0);
        fill(9);
        send_frame(8'h00, -1, 0);
        check("t6_overrun", int'(overrun), 1);
        check("t6_data_held", int'($signed(data_out)), 5);
        idle(1);
        check("t6_overrun_pulse", int'(overrun), 0);
        rdy = 1'b1;
        idle(2);
        fill(200);
        send_frame(8'h00, -1, 0);
`ifdef CDMA_DESPREAD_SAT_EN
        check("t6_sat", int'($signed(data_out)), 127);
`else
        check("t6_trunc", int'(data_out), 8'hC8);
`endif
        idle(2);

        // Reset mid-frame discards the partial frame and the held output
        rdy = 1'b0;
        fill(3);
        send_frame(8'h00, -1, 0);
        for (int j = 0; j < 4; j++) cycle(1'b1, j == 0, 11, 8'h0F);
        rst_r = 1'b1;
        idle(1);
        rst_r = 1'b0;
        check("rst_mid_valid", int'(out_valid), 0);
        rdy = 1'b1;
        for (int j = 1; j < CW; j++) cycle(1'b1, 1'b0, 11, 8'h0F);
        check("rst_mid_no_output", int'(out_valid), 0);
        fill(-6);
        send_frame(8'h0F, -1, 0);
        check("rst_after_data", int'($signed(data_out)), 0);

        // Back-to-back frames and random traffic
        for (int i = 0; i < 600; i++) begin
            logic sv;
            logic fs;
            int   s;
            sv  = ($urandom % 4) != 0;
            fs  = ($urandom % 12) == 0;
            s   = int'($urandom_range(0, 2046)) - 1023;
            rdy = ($urandom % 4) != 0;
            cycle(sv, fs, s, CW'($urandom));
        end
        rdy = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
